// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the LEGv8 execute stage: 4-bit ALU operation codes,
// the R-type opcodes (ins[31:21]) recognised by ALU control, the ALUOp
// encodings driven by main control, and the ALU-control decode function.
// ----------------------------------------------------------------------------
package alu_pkg;

   // ALU operation codes
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_ILL   = 4'b1111;

   // R-type opcodes, ins[31:21]
   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   // ALUOp encodings from main control
   localparam logic [1:0] ALUOP_MEM   = 2'b00;  // loads/stores: address add
   localparam logic [1:0] ALUOP_CBZ   = 2'b01;  // CBZ: pass B through for zero test
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode by opcode
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;  // unused by main control, treated as add

   // ALU-control decode: (ALUOp, opcode) -> ALU operation code
   function automatic logic [3:0] alu_decode(input logic [1:0]  op,
                                             input logic [10:0] opc);
      logic [3:0] code;
      case (op)
         ALUOP_MEM:   code = ALU_ADD;
         ALUOP_CBZ:   code = ALU_PASSB;
         ALUOP_RSVD:  code = ALU_ADD;
         ALUOP_RTYPE: begin
            case (opc)
               OPC_ADD: code = ALU_ADD;
               OPC_SUB: code = ALU_SUB;
               OPC_AND: code = ALU_AND;
               OPC_ORR: code = ALU_ORR;
               default: code = ALU_ILL;
            endcase
         end
         default:     code = ALU_ILL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/add_carry.sv
// ----------------------------------------------------------------------------
// add_carry
// Combinational WIDTH-bit adder with carry-in and carry-out. Sum wraps
// modulo 2^WIDTH; cout_o is the carry out of bit WIDTH-1.
// Ports:
//   a_i, b_i  : WIDTH-bit addends
//   cin_i     : carry-in (1 turns a + ~b into a two's complement subtract)
//   sum_o     : WIDTH-bit sum
//   cout_o    : carry-out
// ----------------------------------------------------------------------------
module add_carry #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH:0] wide_s;

   // Zero-extend by one bit so the top bit of the sum is the carry-out
   assign wide_s = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
   assign sum_o  = wide_s[WIDTH-1:0];
   assign cout_o = wide_s[WIDTH];

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Registered execute stage of the LEGv8 datapath: ALU-control decode, a
// 64-bit ALU with N/Z/C/V flags, and the PC+4 / PC+offset adders. All
// outputs are registered (one-cycle latency) and cleared by async reset.
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   in_valid            : inputs valid this cycle (copied to out_valid)
//   ins                 : instruction; only ins[31:21] is decoded
//   alu_op              : ALUOp from main control
//   data_a, data_b      : ALU operands (B already muxed with immediate)
//   pc, branch_offset   : PC and shifted sign-extended branch offset
//   out_valid, alu_ctrl : registered valid and decoded ALU operation
//   alu_result + flags  : registered result, zero/negative/carry/overflow
//   pc_plus4(_carry)    : registered pc + PC_INC and its carry-out
//   pc_branch(_carry)   : registered pc + branch_offset and its carry-out
// ----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      ins,
   input  logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] branch_offset,
   output logic             out_valid,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             pc_plus4_carry,
   output logic [WIDTH-1:0] pc_branch,
   output logic             pc_branch_carry
);

   localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

   logic [3:0]       ctrl_d;
   logic             is_sub_s;
   logic [WIDTH-1:0] add_b_s;
   logic [WIDTH-1:0] add_sum_s;
   logic             add_cout_s;
   logic [WIDTH-1:0] result_d;
   logic             carry_d;
   logic             overflow_d;
   logic [WIDTH-1:0] pc_plus4_d;
   logic             pc_plus4_carry_d;
   logic [WIDTH-1:0] pc_branch_d;
   logic             pc_branch_carry_d;

   logic             valid_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             negative_q;
   logic             carry_q;
   logic             overflow_q;
   logic [WIDTH-1:0] pc_plus4_q;
   logic             pc_plus4_carry_q;
   logic [WIDTH-1:0] pc_branch_q;
   logic             pc_branch_carry_q;

   // Register/immediate field bits are not needed by ALU control
   logic unused_ins_s;
   assign unused_ins_s = ^ins[20:0];

   // ALU-control decode from ALUOp and the 11-bit opcode
   always_comb begin
      ctrl_d = alu_decode(alu_op, ins[31:21]);
   end

   // Subtract reuses the adder as A + ~B + 1, so carry means "no borrow"
   assign is_sub_s = (ctrl_d == ALU_SUB);
   assign add_b_s  = is_sub_s ? ~data_b : data_b;

   add_carry #(.WIDTH(WIDTH)) u_alu_add (
      .a_i    (data_a),
      .b_i    (add_b_s),
      .cin_i  (is_sub_s),
      .sum_o  (add_sum_s),
      .cout_o (add_cout_s)
   );

   add_carry #(.WIDTH(WIDTH)) u_pc_add (
      .a_i    (pc),
      .b_i    (PC_INC_W),
      .cin_i  (1'b0),
      .sum_o  (pc_plus4_d),
      .cout_o (pc_plus4_carry_d)
   );

   add_carry #(.WIDTH(WIDTH)) u_branch_add (
      .a_i    (pc),
      .b_i    (branch_offset),
      .cin_i  (1'b0),
      .sum_o  (pc_branch_d),
      .cout_o (pc_branch_carry_d)
   );

   // ALU result and C/V flags; C and V are meaningful only for add/sub
   always_comb begin
      result_d   = {WIDTH{1'b0}};
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      case (ctrl_d)
         ALU_AND:   result_d = data_a & data_b;
         ALU_ORR:   result_d = data_a | data_b;
         ALU_ADD, ALU_SUB: begin
            result_d   = add_sum_s;
            carry_d    = add_cout_s;
            // Adder operands share a sign but the sum's sign differs.
            // With B inverted for subtract this is the subtract rule too.
            overflow_d = (data_a[WIDTH-1] == add_b_s[WIDTH-1]) &&
                         (add_sum_s[WIDTH-1] != data_a[WIDTH-1]);
         end
         ALU_PASSB: result_d = data_b;
         ALU_NOR:   result_d = ~(data_a | data_b);
         default:   result_d = {WIDTH{1'b0}};
      endcase
   end

   // Output register bank: loads every cycle, cleared by async reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q           <= 1'b0;
         ctrl_q            <= 4'b0000;
         result_q          <= {WIDTH{1'b0}};
         zero_q            <= 1'b0;
         negative_q        <= 1'b0;
         carry_q           <= 1'b0;
         overflow_q        <= 1'b0;
         pc_plus4_q        <= {WIDTH{1'b0}};
         pc_plus4_carry_q  <= 1'b0;
         pc_branch_q       <= {WIDTH{1'b0}};
         pc_branch_carry_q <= 1'b0;
      end else begin
         valid_q           <= in_valid;
         ctrl_q            <= ctrl_d;
         result_q          <= result_d;
         zero_q            <= (result_d == {WIDTH{1'b0}});
         negative_q        <= result_d[WIDTH-1];
         carry_q           <= carry_d;
         overflow_q        <= overflow_d;
         pc_plus4_q        <= pc_plus4_d;
         pc_plus4_carry_q  <= pc_plus4_carry_d;
         pc_branch_q       <= pc_branch_d;
         pc_branch_carry_q <= pc_branch_carry_d;
      end
   end

   assign out_valid       = valid_q;
   assign alu_ctrl        = ctrl_q;
   assign alu_result      = result_q;
   assign zero            = zero_q;
   assign negative        = negative_q;
   assign carry           = carry_q;
   assign overflow        = overflow_q;
   assign pc_plus4        = pc_plus4_q;
   assign pc_plus4_carry  = pc_plus4_carry_q;
   assign pc_branch       = pc_branch_q;
   assign pc_branch_carry = pc_branch_carry_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: directed scenarios with constant
// expectations, then randomized back-to-back traffic checked against an
// arithmetic reference model of the execute stage.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

   localparam int W = 64;

   localparam logic [10:0] OP_ADD = 11'b10001011000;
   localparam logic [10:0] OP_SUB = 11'b11001011000;
   localparam logic [10:0] OP_AND = 11'b10001010000;
   localparam logic [10:0] OP_ORR = 11'b10101010000;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [31:0]   ins;
   logic [1:0]    alu_op;
   logic [W-1:0]  data_a;
   logic [W-1:0]  data_b;
   logic [W-1:0]  pc;
   logic [W-1:0]  branch_offset;
   logic          out_valid;
   logic [3:0]    alu_ctrl;
   logic [W-1:0]  alu_result;
   logic          zero;
   logic          negative;
   logic          carry;
   logic          overflow;
   logic [W-1:0]  pc_plus4;
   logic          pc_plus4_carry;
   logic [W-1:0]  pc_branch;
   logic          pc_branch_carry;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic         v;
      logic [3:0]   ctrl;
      logic [W-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         o;
      logic [W-1:0] p4;
      logic         p4c;
      logic [W-1:0] pb;
      logic         pbc;
   } exp_t;

   alu_exec_unit #(.WIDTH(W), .PC_INC(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .ins             (ins),
      .alu_op          (alu_op),
      .data_a          (data_a),
      .data_b          (data_b),
      .pc              (pc),
      .branch_offset   (branch_offset),
      .out_valid       (out_valid),
      .alu_ctrl        (alu_ctrl),
      .alu_result      (alu_result),
      .zero            (zero),
      .negative        (negative),
      .carry           (carry),
      .overflow        (overflow),
      .pc_plus4        (pc_plus4),
      .pc_plus4_carry  (pc_plus4_carry),
      .pc_branch       (pc_branch),
      .pc_branch_carry (pc_branch_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference model: what the stage should present one edge after sampling
   function automatic exp_t model(input logic v, input logic [31:0] i,
                                  input logic [1:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] p, input logic [W-1:0] off);
      exp_t e;
      logic [W:0] wide;
      logic signed [W:0] s;
      logic [10:0] opc;
      e = '0;
      e.v = v;
      opc = i[31:21];
      if (op == 2'b01) e.ctrl = 4'b0111;
      else if (op != 2'b10) e.ctrl = 4'b0010;
      else if (opc == OP_ADD) e.ctrl = 4'b0010;
      else if (opc == OP_SUB) e.ctrl = 4'b0110;
      else if (opc == OP_AND) e.ctrl = 4'b0000;
      else if (opc == OP_ORR) e.ctrl = 4'b0001;
      else e.ctrl = 4'b1111;
      if (e.ctrl == 4'b0010) begin
         wide  = {1'b0, a} + {1'b0, b};
         e.res = wide[W-1:0];
         e.c   = wide[W];
         s     = $signed({a[W-1], a}) + $signed({b[W-1], b});
         e.o   = (s[W] != s[W-1]);
      end else if (e.ctrl == 4'b0110) begin
         e.res = a - b;
         e.c   = (a >= b);
         s     = $signed({a[W-1], a}) - $signed({b[W-1], b});
         e.o   = (s[W] != s[W-1]);
      end else if (e.ctrl == 4'b0000) e.res = a & b;
      else if (e.ctrl == 4'b0001) e.res = a | b;
      else if (e.ctrl == 4'b0111) e.res = b;
      else e.res = '0;
      e.z = (e.res == '0);
      e.n = e.res[W-1];
      wide  = {1'b0, p} + 65'd4;
      e.p4  = wide[W-1:0];
      e.p4c = wide[W];
      wide  = {1'b0, p} + {1'b0, off};
      e.pb  = wide[W-1:0];
      e.pbc = wide[W];
      return e;
   endfunction

   function automatic exp_t observed();
      return {out_valid, alu_ctrl, alu_result, zero, negative, carry, overflow,
              pc_plus4, pc_plus4_carry, pc_branch, pc_branch_carry};
   endfunction

   task automatic drive(input logic v, input logic [31:0] i, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] p, input logic [W-1:0] off);
      in_valid = v; ins = i; alu_op = op; data_a = a; data_b = b;
      pc = p; branch_offset = off;
   endtask

   // One capture edge, then sample away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t o;
      o = observed();
      if (o !== '0) begin
         failures++; $display("FAIL reset_initial: got %h, required 0", o);
      end
      checks++;
      reset = 1'b0;
      drive(1'b1, {OP_ADD, 21'd0}, 2'b10, 64'd5, 64'd7, 64'h100, 64'h20);
      step();
      if (alu_result !== 64'd12 || out_valid !== 1'b1) begin
         failures++; $display("FAIL reset_preload: got res=%h v=%b, required res=c v=1", alu_result, out_valid);
      end
      checks++;
      #2 reset = 1'b1;
      #1;
      o = observed();
      if (o !== '0) begin
         failures++; $display("FAIL reset_async: got %h, required 0", o);
      end
      checks++;
      step();
      o = observed();
      if (o !== '0) begin
         failures++; $display("FAIL reset_held: got %h, required 0", o);
      end
      checks++;
      reset = 1'b0;
      drive(1'b1, {OP_ADD, 21'd0}, 2'b10, 64'd1, 64'd2, 64'h0, 64'h0);
      #1;
      if (out_valid !== 1'b0 || alu_result !== 64'd0) begin
         failures++; $display("FAIL reset_before_edge: got v=%b res=%h, required v=0 res=0", out_valid, alu_result);
      end
      checks++;
      step();
      if (out_valid !== 1'b1 || alu_result !== 64'd3) begin
         failures++; $display("FAIL reset_first_capture: got v=%b res=%h, required v=1 res=3", out_valid, alu_result);
      end
      checks++;
   endtask

   task automatic test_add();
      drive(1'b1, {OP_ADD, 21'h1ABCD}, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result, zero, carry, overflow} !== {4'b0010, 64'd0, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL add_wrap: got ctrl=%b res=%h z=%b c=%b v=%b, required ctrl=0010 res=0 z=1 c=1 v=0",
                  alu_ctrl, alu_result, zero, carry, overflow);
      end
      checks++;
   endtask

   task automatic test_sub();
      drive(1'b1, {OP_SUB, 21'd0}, 2'b10, 64'h8000_0000_0000_0000, 64'd1, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result, overflow, carry, negative} !== {4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_overflow: got ctrl=%b res=%h v=%b c=%b n=%b, required ctrl=0110 res=7fffffffffffffff v=1 c=1 n=0",
                  alu_ctrl, alu_result, overflow, carry, negative);
      end
      checks++;
      drive(1'b1, {OP_SUB, 21'd0}, 2'b10, 64'd5, 64'd7, 64'h0, 64'h0);
      step();
      if ({alu_result, carry, negative, overflow} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_borrow: got res=%h c=%b n=%b v=%b, required res=fffffffffffffffe c=0 n=1 v=0",
                  alu_result, carry, negative, overflow);
      end
      checks++;
   endtask

   task automatic test_logic();
      drive(1'b1, {OP_AND, 21'd0}, 2'b10, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result, carry} !== {4'b0000, 64'h00F0, 1'b0}) begin
         failures++; $display("FAIL and: got ctrl=%b res=%h c=%b, required ctrl=0000 res=f0 c=0", alu_ctrl, alu_result, carry);
      end
      checks++;
      drive(1'b1, {OP_ORR, 21'd0}, 2'b10, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result} !== {4'b0001, 64'hFFF0}) begin
         failures++; $display("FAIL orr: got ctrl=%b res=%h, required ctrl=0001 res=fff0", alu_ctrl, alu_result);
      end
      checks++;
      drive(1'b1, {11'b11111111111, 21'd0}, 2'b10, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result, zero} !== {4'b1111, 64'd0, 1'b1}) begin
         failures++; $display("FAIL illegal: got ctrl=%b res=%h z=%b, required ctrl=1111 res=0 z=1", alu_ctrl, alu_result, zero);
      end
      checks++;
   endtask

   task automatic test_cbz_load();
      drive(1'b1, {OP_SUB, 21'd0}, 2'b01, 64'h1234, 64'd0, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result, zero} !== {4'b0111, 64'd0, 1'b1}) begin
         failures++; $display("FAIL cbz_zero: got ctrl=%b res=%h z=%b, required ctrl=0111 res=0 z=1", alu_ctrl, alu_result, zero);
      end
      checks++;
      drive(1'b1, {OP_SUB, 21'd0}, 2'b01, 64'h1234, 64'd3, 64'h0, 64'h0);
      step();
      if ({alu_result, zero} !== {64'd3, 1'b0}) begin
         failures++; $display("FAIL cbz_nonzero: got res=%h z=%b, required res=3 z=0", alu_result, zero);
      end
      checks++;
      drive(1'b1, {OP_AND, 21'd0}, 2'b00, 64'h100, 64'h8, 64'h0, 64'h0);
      step();
      if ({alu_ctrl, alu_result} !== {4'b0010, 64'h108}) begin
         failures++; $display("FAIL load_addr: got ctrl=%b res=%h, required ctrl=0010 res=108", alu_ctrl, alu_result);
      end
      checks++;
   endtask

   task automatic test_adders_valid();
      drive(1'b1, {OP_ADD, 21'd0}, 2'b11, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10);
      step();
      if ({pc_plus4, pc_plus4_carry, pc_branch, pc_branch_carry} !== {64'd0, 1'b1, 64'hC, 1'b1}) begin
         failures++;
         $display("FAIL pc_adders: got p4=%h p4c=%b pb=%h pbc=%b, required p4=0 p4c=1 pb=c pbc=1",
                  pc_plus4, pc_plus4_carry, pc_branch, pc_branch_carry);
      end
      checks++;
      in_valid = 1'b0;
      step();
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL valid_idle: got %b, required 0", out_valid);
      end
      checks++;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1) begin
         failures++; $display("FAIL valid_pulse: got %b, required 1", out_valid);
      end
      checks++;
      step();
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL valid_drop: got %b, required 0", out_valid);
      end
      checks++;
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] r;
      case ($urandom_range(0, 5))
         0:       r = '0;
         1:       r = '1;
         2:       r = 64'h8000_0000_0000_0000;
         3:       r = 64'h7FFF_FFFF_FFFF_FFFF;
         default: r = {$urandom, $urandom};
      endcase
      return r;
   endfunction

   // Randomized back-to-back traffic, one result per edge, random valid
   task automatic test_back_to_back();
      logic [10:0] opcs [5];
      exp_t e, o;
      logic [31:0] i;
      opcs[0] = OP_ADD; opcs[1] = OP_SUB; opcs[2] = OP_AND; opcs[3] = OP_ORR;
      for (int n = 0; n < 400; n++) begin
         opcs[4] = 11'($urandom);
         i = {opcs[$urandom_range(0, 4)], 21'($urandom)};
         drive(1'($urandom), i, 2'($urandom), rand_operand(), rand_operand(),
               rand_operand(), rand_operand());
         e = model(in_valid, ins, alu_op, data_a, data_b, pc, branch_offset);
         step();
         o = observed();
         if (o !== e) begin
            failures++;
            $display("FAIL random[%0d]: got %h, required %h (op=%b ins=%h a=%h b=%h)",
                     n, o, e, alu_op, i, data_a, data_b);
         end
         checks++;
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'd0, 2'b00, '0, '0, '0, '0);
      #1;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_cbz_load();
      test_adders_valid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute stage of the single-cycle LEGv8 datapath, merging three functions into one clocked block.
- ALU-control decode: (instruction opcode, ALUOp) -> 4-bit ALU operation code.
- 64-bit ALU with zero/negative/carry/overflow flags.
- Two 64-bit carry-out adders: PC+4 and PC+branch-offset.
- Sits between register bank/sign-extend/shift and data memory/PC mux; all outputs registered, one cycle latency.

Parameters:
- WIDTH, 64, datapath width of ALU operands, result and both adders.
- PC_INC, 4, constant added to pc by the sequential-PC adder.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all registered outputs
- in_valid  input  1  operands/instruction valid this cycle
- ins  input  32  current instruction; only ins[31:21] (opcode) is decoded
- alu_op  input  2  ALUOp from main control
- data_a  input  WIDTH  ALU operand A (register Rn)
- data_b  input  WIDTH  ALU operand B (register or sign-extended immediate, already muxed)
- pc  input  WIDTH  current program counter
- branch_offset  input  WIDTH  sign-extended offset already shifted left by 2
- out_valid  output  1  registered copy of in_valid
- alu_ctrl  output  4  registered decoded ALU operation
- alu_result  output  WIDTH  registered ALU result
- zero  output  1  registered; alu_result == 0
- negative  output  1  registered; alu_result[WIDTH-1]
- carry  output  1  registered ALU carry
- overflow  output  1  registered signed overflow
- pc_plus4  output  WIDTH  registered pc + PC_INC
- pc_plus4_carry  output  1  carry-out of the PC adder
- pc_branch  output  WIDTH  registered pc + branch_offset
- pc_branch_carry  output  1  carry-out of the branch adder

Behaviour:
- Reset (async, active-high): all outputs 0, including out_valid and zero. Reset asserted mid-operation discards the in-flight result immediately. First capture occurs on the first rising clk after reset deasserts.
- Latency: inputs sampled on rising clk; outputs update at the same edge and hold until the next edge.
- Registers load every cycle regardless of in_valid; out_valid <= in_valid. Consumers must ignore data when out_valid=0.
- ALU-control decode:
  - alu_op 00 -> 0010 (add; loads/stores).
  - alu_op 01 -> 0111 (pass B; CBZ).
  - alu_op 11 -> 0010.
  - alu_op 10 (R-type), by opcode ins[31:21]:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - any other opcode -> 1111 (illegal)
- ALU ops by alu_ctrl:
  - 0000: A & B
  - 0001: A | B
  - 0010: A + B
  - 0110: A + ~B + 1
  - 0111: B
  - 1100: ~(A | B)
  - any other code (incl. 1111): result 0
- Arithmetic wraps modulo 2^WIDTH.
- Flags:
  - carry: add -> carry-out of bit WIDTH-1; sub -> carry-out of A+~B+1 (1 = no borrow, ARM convention); all other ops -> 0.
  - overflow: add -> operands same sign and result sign differs; sub -> operands differ in sign and result sign differs from A; all other ops -> 0.
  - zero and negative are derived from the result for every op.
- Adders:
  - pc_plus4 = pc + PC_INC, with carry-out.
  - pc_branch = pc + branch_offset, with carry-out.
  - Both wrap and are computed every cycle independent of alu_op.

Decomposition:
- Shared package alu_pkg:
  - ALU_AND=4'b0000, ALU_ORR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111, ALU_NOR=4'b1100, ALU_ILL=4'b1111.
  - Opcode constants OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR.
  - ALUOp encodings.
- One sub-module, add_carry: parameterised WIDTH-bit adder with carry-in and carry-out. Instantiate it three times: ALU add/sub path, PC adder, branch adder.
- Decode and ALU logic stay combinational in the top, followed by one output register bank.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; release reset -> first valid result appears one edge after the inputs are applied.
- ADD: alu_op=10, opcode 10001011000, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> alu_ctrl=0010, result=0, zero=1, carry=1, overflow=0.
- SUB: opcode 11001011000, A=0x8000_0000_0000_0000, B=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1, negative=0. Also A=5, B=7 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
- AND/ORR and illegal opcode: A=0xF0F0, B=0x0FF0 -> AND result 0x00F0, ORR result 0xFFF0. Opcode 11111111111 with alu_op=10 -> alu_ctrl=1111, result=0, zero=1.
- CBZ/load: alu_op=01, B=0 -> result 0, zero=1; B=3 -> zero=0. alu_op=00, A=0x100, B=0x8 -> result=0x108.
- Adders and valid: pc=0xFFFF_FFFF_FFFF_FFFC, branch_offset=0x10 -> pc_plus4=0, pc_plus4_carry=1, pc_branch=0xC, pc_branch_carry=1. Pulse in_valid for one cycle -> out_valid high for exactly the following cycle.
